addsub_accum_mc: RTL and testbench
==================================

// Module: addsub_accum_mc
// PURPOSE
//  Multi-channel signed add/subtract accumulator: 2-stage pipeline with valid/ready handshakes.
//  Each channel keeps its own running accumulator. Overflow can wrap or saturate, set by a
//  parameter. Sits between an operand source and a result sink.
// PARAMETERS
//  N         16  operand/result width, two's complement, N>=4
//  CHANNELS  4   accumulator count, power of 2, >=2
//  CW        2   channel index width, $clog2(CHANNELS)
//  SATURATE  0   0: wrap on overflow; 1: clamp to +max/-min
// PORTS
//  Clock       in   1         rising-edge clock
//  Resetn      in   1         async active-low reset
//  In_Valid    in   1         operand beat valid
//  In_Ready    out  1         block accepts beat this cycle
//  In_Chan     in   CW        target channel
//  A           in   N         first operand, used when Sel=0
//  B           in   N         second operand
//  Sel         in   1         0: X=A; 1: X=acc[In_Chan]
//  AddSub      in   1         0: X+B; 1: X-B
//  Clear       in   1         zero acc[In_Chan]; op ignored
//  Out_Valid   out  1         result beat valid
//  Out_Ready   in   1         sink accepts result
//  Out_Chan    out  CW        channel of result
//  Z           out  N         result
//  Overflow    out  1         signed overflow of this op
//  Sticky_Ovf  out  CHANNELS  per-channel sticky overflow
// BEHAVIOUR
//  - Reset (async, Resetn=0): Out_Valid=0, Z=0, Out_Chan=0, Overflow=0, Sticky_Ovf=0,
//    all acc=0, both stage valids=0. In_Ready=1 from the first clock edge after release.
//  - Accept: an input beat transfers when In_Valid & In_Ready. Output transfers when Out_Valid & Out_Ready.
//  - S1: registers all inputs on accept. S2: computes, loads Z/Overflow/Out_Chan, writes acc.
//  - Latency: Z is visible exactly 2 edges after accept, with no stall. Full rate: 1 beat/cycle.
//  - Stall: S2 holds while Out_Valid & !Out_Ready. S1 holds when S2 holds.
//  - In_Ready = !s1_valid | !Out_Valid | Out_Ready (combinational).
//  - No bubbles when unstalled. No data loss or duplication under any Out_Ready pattern.
//  - Compute in S2: X = Sel ? acc[ch] : A. R = AddSub ? X-B : X+B, taken as N+1 bits.
//  - Overflow: signed overflow, i.e. the operand signs satisfy the overflow rule and the sign of R[N-1] differs.
//  - SATURATE=0: Z = R[N-1:0].
//  - SATURATE=1, on overflow: Z = 2^(N-1)-1 if the true result is positive, else -2^(N-1).
//  - On S2 load: acc[ch] <= Z and Sticky_Ovf[ch] |= Overflow.
//  - Clear: Z=0, Overflow=0, acc[ch]=0, Sticky_Ovf[ch]=0. A result beat is still emitted.
//  - Accumulator is read in S2. Back-to-back Sel=1 beats on one channel see the previous result.
//    No forwarding logic is needed.
//  - acc and Sticky_Ovf change only on S2 load, never while stalled.
//  - Other channels are never disturbed.
//  - Reset asserted mid-stream drops all in-flight beats. Nothing is emitted for them after release.
// STRUCTURE
//  - Package addsub_accum_pkg holds:
//    - op encodings ADD=0, SUB=1, SEL_A=0, SEL_ACC=1
//    - function sat_limit(N, sign) returning +max/-min.
//  - Sub-module addsub_sat_core: combinational (X, B, AddSub, SATURATE) -> (Z, Overflow).
//  - Top holds: S1/S2 registers, the acc array, Sticky_Ovf and the handshake logic.
// TESTING
//  - T1 reset: Resetn=0 mid-beat -> Out_Valid=0, Z=0, Sticky_Ovf=0.
//    After release, ch0 Sel=1 B=0 add -> Z=0.
//  - T2 basic: ch0 A=132 B=63 Sel=0 sub -> Z=69, Ovf=0, 2 edges after accept.
//    Then A=750 B=120 sub -> Z=630.
//  - T3 accumulate/wrap, SATURATE=0, ch0 from 630: Sel=1 B=7000 add -> 7630.
//    Then Sel=1 B=30000 add -> Z=37630 (0x92FE), Ovf=1, Sticky_Ovf[0]=1.
//  - T4 saturate, SATURATE=1, same sequence -> last Z=32767, Ovf=1.
//    Then Sel=1 B=1 sub -> 32766, Ovf=0.
//  - T5 channels: interleave ch1 +5 x4 and ch2 -3 x4, Sel=1, back-to-back -> ch1=20, ch2=-12.
//    ch0 and its sticky bit unchanged. Clear on ch1 -> acc=0, Sticky_Ovf[1]=0.
//  - T6 backpressure: random Out_Ready (~50%), 200 beats, scoreboard vs reference model.
//    -> In-order, no loss, no duplicates; acc matches the model.

Source files
------------

// File: rtl/addsub_accum_pkg.sv
// Shared encodings and the saturation limit helper for the add/sub accumulator.
package addsub_accum_pkg;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_ACC = 1'b1;

  // 64-bit pattern whose low n bits are +max (neg=0) or -min (neg=1) for an n-bit signed value.
  function automatic logic [63:0] sat_limit(input int n, input logic neg);
    logic [63:0] low;
    low = {64{1'b1}} << (n - 1);
    return neg ? low : ~low;
  endfunction
endpackage

// File: rtl/addsub_accum_mc_if.sv
// Operand-in / result-out handshake bundle; slave is the accumulator's view.
interface addsub_accum_mc_if #(
  parameter int N        = 16,
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS)
);
  logic                In_Valid;
  logic                In_Ready;
  logic [CW-1:0]       In_Chan;
  logic [N-1:0]        A;
  logic [N-1:0]        B;
  logic                Sel;
  logic                AddSub;
  logic                Clear;
  logic                Out_Valid;
  logic                Out_Ready;
  logic [CW-1:0]       Out_Chan;
  logic [N-1:0]        Z;
  logic                Overflow;
  logic [CHANNELS-1:0] Sticky_Ovf;

  modport master (
    output In_Valid, In_Chan, A, B, Sel, AddSub, Clear, Out_Ready,
    input  In_Ready, Out_Valid, Out_Chan, Z, Overflow, Sticky_Ovf
  );
  modport slave (
    input  In_Valid, In_Chan, A, B, Sel, AddSub, Clear, Out_Ready,
    output In_Ready, Out_Valid, Out_Chan, Z, Overflow, Sticky_Ovf
  );
endinterface

// File: rtl/addsub_sat_core.sv
// Combinational signed add/subtract with overflow detect and optional clamp.
module addsub_sat_core
  import addsub_accum_pkg::*;
#(
  parameter int N        = 16,
  parameter int SATURATE = 0
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] b,
  input  logic         add_sub,
  output logic [N-1:0] z,
  output logic         overflow
);
  logic [N:0]  r;
  logic [63:0] lim;
  logic        unused_lim;

  // Sign-extended N+1 bit result: r[N] is the sign of the true result.
  assign r = (add_sub == OP_SUB) ? {x[N-1], x} - {b[N-1], b}
                                 : {x[N-1], x} + {b[N-1], b};

  assign overflow = (add_sub == OP_SUB) ? (x[N-1] != b[N-1]) && (r[N-1] != x[N-1])
                                        : (x[N-1] == b[N-1]) && (r[N-1] != x[N-1]);

  assign lim        = sat_limit(N, r[N]);
  assign unused_lim = ^lim[63:N];
  assign z          = (SATURATE != 0 && overflow) ? lim[N-1:0] : r[N-1:0];
endmodule

// File: rtl/addsub_accum_mc.sv
// Multi-channel signed add/sub accumulator: S1 captures the beat, S2 computes and writes back.
module addsub_accum_mc
  import addsub_accum_pkg::*;
#(
  parameter int N        = 16,
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS),
  parameter int SATURATE = 0
) (
  input logic               Clock,
  input logic               Resetn,
  addsub_accum_mc_if.slave  bus
);
  typedef struct packed {
    logic [CW-1:0] chan;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          sel;
    logic          add_sub;
    logic          clear;
  } beat_t;

  beat_t                      s1, beat_in;
  logic [2:1]                 vld_pipe;
  logic                       stall, s1_hold, accept;
  logic [CHANNELS-1:0][N-1:0] acc;
  logic [CHANNELS-1:0]        sticky;
  logic [N-1:0]               x, core_z, z_nxt, z_q;
  logic                       core_ovf, ovf_nxt, ovf_q;
  logic [CW-1:0]              chan_q;

  assign stall   = vld_pipe[2] & ~bus.Out_Ready;
  assign s1_hold = vld_pipe[1] & stall;
  assign accept  = bus.In_Valid & ~s1_hold;

  assign beat_in = '{chan: bus.In_Chan, a: bus.A, b: bus.B, sel: bus.Sel,
                     add_sub: bus.AddSub, clear: bus.Clear};

  // acc is read here, one cycle after the previous beat wrote it, so no forwarding is needed.
  assign x = (s1.sel == SEL_ACC) ? acc[s1.chan] : s1.a;

  addsub_sat_core #(.N(N), .SATURATE(SATURATE)) u_core (
    .x        (x),
    .b        (s1.b),
    .add_sub  (s1.add_sub),
    .z        (core_z),
    .overflow (core_ovf)
  );

  assign z_nxt   = s1.clear ? '0 : core_z;
  assign ovf_nxt = ~s1.clear & core_ovf;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      vld_pipe <= '0;
      s1       <= '0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      chan_q   <= '0;
      acc      <= '0;
      sticky   <= '0;
    end else begin
      if (!s1_hold) begin
        vld_pipe[1] <= accept;
        if (accept) s1 <= beat_in;
      end
      if (!stall) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          z_q          <= z_nxt;
          ovf_q        <= ovf_nxt;
          chan_q       <= s1.chan;
          acc[s1.chan] <= z_nxt;
          sticky[s1.chan] <= s1.clear ? 1'b0 : (sticky[s1.chan] | core_ovf);
        end
      end
    end
  end

  assign bus.In_Ready   = ~s1_hold;
  assign bus.Out_Valid  = vld_pipe[2];
  assign bus.Out_Chan   = chan_q;
  assign bus.Z          = z_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Sticky_Ovf = sticky;
endmodule

// File: tb/tb_addsub_accum_mc.sv
// Drives a wrapping and a saturating instance in lockstep and scoreboards both against a model.
module tb_addsub_accum_mc;
  import addsub_accum_pkg::*;

  localparam int N    = 16;
  localparam int CH   = 4;
  localparam int CW   = $clog2(CH);
  localparam int MAXV = (1 << (N - 1)) - 1;
  localparam int MINV = -(1 << (N - 1));

  typedef struct {
    int             ch;
    logic [N-1:0]   z0, z1;
    logic           o0, o1;
    logic [CH-1:0]  s0, s1;
    int             cyc;
  } exp_t;

  logic Clock = 1'b0;
  logic Resetn;
  int   n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0;
  bit   lat_chk = 0;
  exp_t sb[$];
  int   acc0[CH], acc1[CH];
  logic [CH-1:0] st0, st1;
  logic [N-1:0]  last_z0, last_z1;
  logic          last_o0, last_o1;

  addsub_accum_mc_if #(.N(N), .CHANNELS(CH)) ia ();
  addsub_accum_mc_if #(.N(N), .CHANNELS(CH)) ib ();

  assign ib.In_Valid  = ia.In_Valid;
  assign ib.In_Chan   = ia.In_Chan;
  assign ib.A         = ia.A;
  assign ib.B         = ia.B;
  assign ib.Sel       = ia.Sel;
  assign ib.AddSub    = ia.AddSub;
  assign ib.Clear     = ia.Clear;
  assign ib.Out_Ready = ia.Out_Ready;

  addsub_accum_mc #(.N(N), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
    .Clock(Clock), .Resetn(Resetn), .bus(ia));
  addsub_accum_mc #(.N(N), .CHANNELS(CH), .SATURATE(1)) dut_sat (
    .Clock(Clock), .Resetn(Resetn), .bus(ib));

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void calc(input int x, input int b, input bit sub, input bit sat,
                               output int z, output bit ovf);
    int r;
    r   = sub ? x - b : x + b;
    ovf = (r > MAXV) || (r < MINV);
    if (!ovf)     z = r;
    else if (sat) z = (r > 0) ? MAXV : MINV;
    else          z = (r > MAXV) ? r - (1 << N) : r + (1 << N);
  endfunction

  task automatic model_reset();
    sb.delete();
    foreach (acc0[i]) begin acc0[i] = 0; acc1[i] = 0; end
    st0 = '0; st1 = '0;
  endtask

  // Scoreboard: pop/compare on output transfer, predict and push on input transfer.
  always @(negedge Clock) begin
    exp_t e;
    int z0, z1, x0, x1, bv, ch;
    bit o0, o1;
    logic [31:0] w;
    if (Resetn) begin
      if (ia.Out_Valid && ia.Out_Ready) begin
        if (sb.size() == 0) chk("spurious_out", ia.Out_Valid, 0);
        else begin
          e = sb.pop_front();
          chk("chan",       ia.Out_Chan,   e.ch);
          chk("z_wrap",     ia.Z,          e.z0);
          chk("ovf_wrap",   ia.Overflow,   e.o0);
          chk("sticky_wrap",ia.Sticky_Ovf, e.s0);
          chk("vld_sat",    ib.Out_Valid,  1);
          chk("z_sat",      ib.Z,          e.z1);
          chk("ovf_sat",    ib.Overflow,   e.o1);
          chk("sticky_sat", ib.Sticky_Ovf, e.s1);
          if (lat_chk) chk("latency", cyc, e.cyc + 2);
          last_z0 = ia.Z; last_z1 = ib.Z; last_o0 = ia.Overflow; last_o1 = ib.Overflow;
        end
      end
      if (ia.In_Valid && ia.In_Ready) begin
        ch = int'(ia.In_Chan);
        bv = int'($signed(ia.B));
        x0 = ia.Sel ? acc0[ch] : int'($signed(ia.A));
        x1 = ia.Sel ? acc1[ch] : int'($signed(ia.A));
        if (ia.Clear) begin
          z0 = 0; z1 = 0; o0 = 0; o1 = 0; st0[ch] = 1'b0; st1[ch] = 1'b0;
        end else begin
          calc(x0, bv, ia.AddSub, 1'b0, z0, o0);
          calc(x1, bv, ia.AddSub, 1'b1, z1, o1);
          st0[ch] = st0[ch] | o0;
          st1[ch] = st1[ch] | o1;
        end
        acc0[ch] = z0; acc1[ch] = z1;
        e.ch = ch;
        w = z0; e.z0 = w[N-1:0];
        w = z1; e.z1 = w[N-1:0];
        e.o0 = o0; e.o1 = o1; e.s0 = st0; e.s1 = st1; e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge Clock); #1;
      ia.Out_Ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  task automatic send(input int ch, input int a, input int b, input logic sel,
                      input logic sub, input logic clr);
    int n;
    ia.In_Valid = 1'b1;
    ia.In_Chan  = CW'(ch);
    ia.A = N'(a); ia.B = N'(b);
    ia.Sel = sel; ia.AddSub = sub; ia.Clear = clr;
    n = 0;
    @(negedge Clock);
    while (!ia.In_Ready && n < 1000) begin @(negedge Clock); n++; end
    if (n >= 1000) chk("send_timeout", ia.In_Ready, 1);
    @(posedge Clock); #1;
    ia.In_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    ia.In_Valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin @(posedge Clock); n++; end
    chk("drain", sb.size(), 0);
    @(posedge Clock); #1;
  endtask

  task automatic readback(input int ch);
    last_z0 = '1; last_z1 = '1;
    send(ch, 0, 0, SEL_ACC, OP_ADD, 1'b0);
    drain();
  endtask

  initial begin
    Resetn = 1'b0;
    ia.In_Valid = 0; ia.In_Chan = '0; ia.A = '0; ia.B = '0;
    ia.Sel = 0; ia.AddSub = 0; ia.Clear = 0; ia.Out_Ready = 0;
    model_reset();
    repeat (2) @(posedge Clock); #1;
    chk("rst_vld", ia.Out_Valid, 0);
    chk("rst_z", ia.Z, 0);
    Resetn = 1'b1;

    // T1: reset with two beats in flight; neither may emerge afterwards.
    send(0, 100, 5, SEL_A, OP_ADD, 1'b0);
    send(0, 7, 1, SEL_A, OP_ADD, 1'b0);
    chk("t1_pre_vld", ia.Out_Valid, 1);
    Resetn = 1'b0;
    #1;
    model_reset();
    chk("t1_rst_vld",    ia.Out_Valid, 0);
    chk("t1_rst_z",      ia.Z, 0);
    chk("t1_rst_ovf",    ia.Overflow, 0);
    chk("t1_rst_chan",   ia.Out_Chan, 0);
    chk("t1_rst_sticky", ia.Sticky_Ovf, 0);
    chk("t1_rst_vld_s",  ib.Out_Valid, 0);
    repeat (2) @(posedge Clock); #1;
    Resetn = 1'b1;
    rdy_mode = 1;
    @(posedge Clock); #1;
    chk("t1_in_ready", ia.In_Ready, 1);
    repeat (4) begin @(negedge Clock); chk("t1_no_emit", ia.Out_Valid, 0); end
    lat_chk = 1;
    readback(0);
    chk("t1_acc0", last_z0, 0);

    // T2: basic subtract from A
    send(0, 132, 63, SEL_A, OP_SUB, 1'b0); drain();
    chk("t2_z69", last_z0, 69);
    chk("t2_ovf", last_o0, 0);
    send(0, 750, 120, SEL_A, OP_SUB, 1'b0); drain();
    chk("t2_z630", last_z0, 630);

    // T3/T4: accumulate into overflow, wrap vs saturate
    send(0, 0, 7000, SEL_ACC, OP_ADD, 1'b0); drain();
    chk("t3_z7630", last_z0, 7630);
    send(0, 0, 30000, SEL_ACC, OP_ADD, 1'b0); drain();
    chk("t3_wrap_z",   last_z0, 16'h92FE);
    chk("t3_wrap_ovf", last_o0, 1);
    chk("t3_sticky0",  ia.Sticky_Ovf[0], 1);
    chk("t4_sat_z",    last_z1, 16'h7FFF);
    chk("t4_sat_ovf",  last_o1, 1);
    send(0, 0, 1, SEL_ACC, OP_SUB, 1'b0); drain();
    chk("t4_sat_dec",  last_z1, 32766);
    chk("t4_dec_ovf",  last_o1, 0);
    chk("t3_wrap_dec", last_z0, 16'h92FD);

    // T5: interleaved channels back-to-back
    for (int i = 0; i < 4; i++) begin
      send(1, 0, 5, SEL_ACC, OP_ADD, 1'b0);
      send(2, 0, 3, SEL_ACC, OP_SUB, 1'b0);
    end
    drain();
    readback(1); chk("t5_ch1", last_z0, 20);
    readback(2); chk("t5_ch2", last_z0, 16'hFFF4);
    readback(0);
    chk("t5_ch0_wrap", last_z0, 16'h92FD);
    chk("t5_ch0_sat",  last_z1, 32766);
    chk("t5_sticky0",  ia.Sticky_Ovf[0], 1);
    send(1, 32767, 1, SEL_A, OP_ADD, 1'b0); drain();
    chk("t5_sticky1_set", ia.Sticky_Ovf[1], 1);
    send(1, 0, 0, SEL_A, OP_ADD, 1'b1); drain();
    chk("t5_clr_z",       last_z0, 0);
    chk("t5_clr_sticky1", ia.Sticky_Ovf[1], 0);
    chk("t5_clr_sticky1s",ib.Sticky_Ovf[1], 0);
    readback(1); chk("t5_clr_acc", last_z1, 0);

    // T6: random traffic under random backpressure
    lat_chk  = 0;
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ia.In_Valid = 1'b0;
        @(posedge Clock); #1;
      end
      send($urandom_range(0, CH - 1), $urandom_range(0, 65535), $urandom_range(0, 65535),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    drain();
    rdy_mode = 1;
    repeat (2) @(posedge Clock); #1;
    for (int c = 0; c < CH; c++) readback(c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
